vip_pattern_gen: RTL and testbench

Synthesisable, parametrised video test-pattern source that writes raster frames into a downstream FIFO write port. It is the next generation of the frame generator used to feed `vip_top`: it drives the same `fifo_data`/`fifo_wrreq`/`fifo_full` interface, but it runs in hardware, has a selectable pattern mode and runtime-programmable frame geometry, and reports run progress. It sits directly in front of the pipeline's input FIFO.

---
 rtl/vip_pattern_gen_if.sv | 11 +
 rtl/vip_pattern_gen.sv | 163 ++++++++++++++++
 tb/tb_vip_pattern_gen.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vip_pattern_gen_if.sv
// FIFO write port between the pattern generator (master) and the pipeline input FIFO (slave).
interface vip_pattern_gen_if #(
    parameter int unsigned DWIDTH = 24
) ();
    logic [DWIDTH-1:0] fifo_data;
    logic              fifo_wrreq;
    logic              fifo_full;

    modport master (output fifo_data, output fifo_wrreq, input fifo_full);
    modport slave  (input fifo_data, input fifo_wrreq, output fifo_full);
endinterface

// File: rtl/vip_pattern_gen.sv
// Raster test-pattern source: ramp, colour bars, checkerboard or solid frames
// written into a downstream FIFO, with runtime geometry and run progress flags.
module vip_pattern_gen #(
    parameter int unsigned DWIDTH   = 24,
    parameter int unsigned WBITS    = 11,
    parameter int unsigned CHK_LOG2 = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [WBITS-1:0]     width,
    input  logic [WBITS-1:0]     height,
    input  logic [WBITS-1:0]     num_frame,
    input  logic [DWIDTH-1:0]    solid_color,
    vip_pattern_gen_if.master    fifo,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 done
);
    localparam int unsigned CW = DWIDTH / 3;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [WBITS-1:0]   width_q, width_d, height_q, height_d, nframe_q, nframe_d;
    logic [WBITS-1:0]   bw_q, bw_d;
    logic [DWIDTH-1:0]  solid_q, solid_d;
    logic [WBITS-1:0]   x_q, x_d, y_q, y_d, frm_q, frm_d, bar_q, bar_d;
    logic [2:0]         idx_q, idx_d;
    logic [DWIDTH-1:0]  data_q, data_d;
    logic               frame_done_d, done_d;
    logic               wr_c, chk_c;
    logic [WBITS-1:0]   bw_in_c;

    assign wr_c            = (state_q == S_RUN) & ~fifo.fifo_full;
    assign fifo.fifo_wrreq = wr_c;
    assign fifo.fifo_data  = data_q;
    assign busy            = (state_q == S_RUN);
    // Bar width is an eighth of the line, never less than one pixel
    assign bw_in_c = ((width >> 3) == WBITS'(0)) ? WBITS'(1) : (width >> 3);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mode_q     <= 2'd0;
            width_q    <= '0;
            height_q   <= '0;
            nframe_q   <= '0;
            bw_q       <= '0;
            solid_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            frm_q      <= '0;
            bar_q      <= '0;
            idx_q      <= 3'd0;
            data_q     <= '0;
            frame_done <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            width_q    <= width_d;
            height_q   <= height_d;
            nframe_q   <= nframe_d;
            bw_q       <= bw_d;
            solid_q    <= solid_d;
            x_q        <= x_d;
            y_q        <= y_d;
            frm_q      <= frm_d;
            bar_q      <= bar_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            frame_done <= frame_done_d;
            done       <= done_d;
        end
    end

    // Run control and raster counters; everything holds unless a pixel is accepted
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        width_d      = width_q;
        height_d     = height_q;
        nframe_d     = nframe_q;
        bw_d         = bw_q;
        solid_d      = solid_q;
        x_d          = x_q;
        y_d          = y_q;
        frm_d        = frm_q;
        bar_d        = bar_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((width == WBITS'(0)) || (height == WBITS'(0)) || (num_frame == WBITS'(0))) begin
                        done_d = 1'b1;
                    end else begin
                        mode_d   = mode;
                        width_d  = width;
                        height_d = height;
                        nframe_d = num_frame;
                        bw_d     = bw_in_c;
                        solid_d  = solid_color;
                        x_d      = '0;
                        y_d      = '0;
                        frm_d    = '0;
                        bar_d    = '0;
                        idx_d    = 3'd0;
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (wr_c) begin
                    if (x_q == width_q - WBITS'(1)) begin
                        x_d   = '0;
                        bar_d = '0;
                        idx_d = 3'd0;
                        if (y_q == height_q - WBITS'(1)) begin
                            y_d          = '0;
                            frm_d        = frm_q + WBITS'(1);
                            frame_done_d = 1'b1;
                            if (frm_q == nframe_q - WBITS'(1)) begin
                                done_d  = 1'b1;
                                state_d = S_IDLE;
                            end
                        end else begin
                            y_d = y_q + WBITS'(1);
                        end
                    end else begin
                        x_d = x_q + WBITS'(1);
                        if (bar_q == bw_q - WBITS'(1)) begin
                            bar_d = '0;
                            if (idx_q != 3'd7) begin
                                idx_d = idx_q + 3'd1;
                            end
                        end else begin
                            bar_d = bar_q + WBITS'(1);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pixel for the next counter position, so fifo_data leaves a register
    always_comb begin
        chk_c  = ~(x_d[CHK_LOG2] ^ y_d[CHK_LOG2] ^ frm_d[0]);
        data_d = solid_d;
        case (mode_d)
            2'd0:    data_d = DWIDTH'({CW'(x_d), CW'(y_d), CW'(frm_d)});
            2'd1:    data_d = DWIDTH'({{CW{~idx_d[1]}}, {CW{~idx_d[2]}}, {CW{~idx_d[0]}}});
            2'd2:    data_d = {DWIDTH{chk_c}};
            default: data_d = solid_d;
        endcase
    end

endmodule

// File: tb/tb_vip_pattern_gen.sv
// Bench for vip_pattern_gen: a frame-level reference model checked every cycle,
// plus literal pixel values and latencies for the directed scenarios.
module tb_vip_pattern_gen;
    localparam int unsigned DW = 24;
    localparam int unsigned WB = 11;

    typedef struct {
        logic [DW-1:0] d;
        bit            lf;
        bit            lr;
    } exp_t;

    logic          clock       = 1'b0;
    logic          reset       = 1'b1;
    logic          start       = 1'b0;
    logic [1:0]    mode        = 2'd0;
    logic [WB-1:0] width       = '0;
    logic [WB-1:0] height      = '0;
    logic [WB-1:0] num_frame   = '0;
    logic [DW-1:0] solid_color = '0;
    logic          busy, frame_done, done;

    vip_pattern_gen_if #(.DWIDTH(DW)) fifo ();

    vip_pattern_gen #(.DWIDTH(DW), .WBITS(WB), .CHK_LOG2(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .width      (width),
        .height     (height),
        .num_frame  (num_frame),
        .solid_color(solid_color),
        .fifo       (fifo),
        .busy       (busy),
        .frame_done (frame_done),
        .done       (done)
    );

    always #5 clock = ~clock;

    int            tests = 0, fails = 0;
    int            cyc = 0, done_cyc = 0, done_cnt = 0, fd_cnt = 0;
    exp_t          mq[$];
    bit            m_busy = 0, m_fd = 0, m_done = 0;
    logic [DW-1:0] wr_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pattern rules evaluated directly from pixel coordinates
    function automatic logic [DW-1:0] ref_pixel(input int md, input int x, input int y,
                                                input int f, input int w, input logic [DW-1:0] sc);
        logic [DW-1:0] r;
        int bw, idx;
        case (md)
            0: r = {8'(x), 8'(y), 8'(f)};
            1: begin
                bw  = (w / 8 < 1) ? 1 : w / 8;
                idx = (x / bw > 7) ? 7 : x / bw;
                case (idx)
                    0:       r = 24'hFFFFFF;
                    1:       r = 24'hFFFF00;
                    2:       r = 24'h00FFFF;
                    3:       r = 24'h00FF00;
                    4:       r = 24'hFF00FF;
                    5:       r = 24'hFF0000;
                    6:       r = 24'h0000FF;
                    default: r = 24'h000000;
                endcase
            end
            2: r = (((x / 8) + (y / 8) + f) % 2 == 0) ? 24'hFFFFFF : 24'h000000;
            default: r = sc;
        endcase
        return r;
    endfunction

    task automatic model_load(input int md, input int w, input int h, input int nf,
                              input logic [DW-1:0] sc);
        exp_t e;
        for (int f = 0; f < nf; f++)
            for (int y = 0; y < h; y++)
                for (int x = 0; x < w; x++) begin
                    e.d  = ref_pixel(md, x, y, f, w, sc);
                    e.lf = (x == w - 1) && (y == h - 1);
                    e.lr = e.lf && (f == nf - 1);
                    mq.push_back(e);
                end
    endtask

    task automatic model_clear();
        mq.delete();
        m_busy = 0;
        m_fd   = 0;
        m_done = 0;
    endtask

    // Model advance at each active edge, from the inputs the DUT samples
    initial forever begin
        exp_t e;
        @(posedge clock);
        cyc++;
        if (!reset) begin
            m_fd   = 0;
            m_done = 0;
            if (m_busy) begin
                if (!fifo.fifo_full && mq.size() > 0) begin
                    e      = mq.pop_front();
                    m_fd   = e.lf;
                    m_done = e.lr;
                    if (e.lr) m_busy = 0;
                end
            end else if (start) begin
                if (width == 0 || height == 0 || num_frame == 0) m_done = 1;
                else begin
                    model_load(int'(mode), int'(width), int'(height), int'(num_frame), solid_color);
                    m_busy = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("wrreq", 32'(fifo.fifo_wrreq), 32'(m_busy && !fifo.fifo_full));
            if (m_busy && !fifo.fifo_full && mq.size() > 0)
                check("data", 32'(fifo.fifo_data), 32'(mq[0].d));
            check("frame_done", 32'(frame_done), 32'(m_fd));
            check("done", 32'(done), 32'(m_done));
            if (fifo.fifo_wrreq) wr_log.push_back(fifo.fifo_data);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (frame_done) fd_cnt++;
        end
    end

    task automatic run(input logic [1:0] md, input int w, input int h, input int nf,
                       input logic [DW-1:0] sc, output int t0);
        @(posedge clock); #1;
        mode        = md;
        width       = WB'(w);
        height      = WB'(h);
        num_frame   = WB'(nf);
        solid_color = sc;
        start       = 1'b1;
        @(posedge clock); #1;
        t0          = cyc;
        start       = 1'b0;
        // Disturb the config mid-run; the latched copy must be used
        mode        = ~md;
        width       = WB'(w + 3);
        height      = WB'(h + 1);
        num_frame   = WB'(nf + 2);
        solid_color = ~sc;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || m_busy) && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        check("idle_within_budget", 32'(busy), 32'd0);
        @(negedge clock); #1;
    endtask

    task automatic clear_logs();
        wr_log.delete();
        done_cnt = 0;
        fd_cnt   = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, lat1;
        logic [DW-1:0] ramp_exp[8];
        ramp_exp = '{24'h000000, 24'h010000, 24'h020000, 24'h030000,
                     24'h000100, 24'h010100, 24'h020100, 24'h030100};
        fifo.fifo_full = 1'b0;

        // Reset state
        @(negedge clock); #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wrreq", 32'(fifo.fifo_wrreq), 32'd0);
        check("rst_data", 32'(fifo.fifo_data), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Ramp without backpressure
        clear_logs();
        run(2'd0, 4, 2, 1, 24'h0, t0);
        wait_idle(100);
        lat1 = done_cyc - t0;
        check("ramp_count", 32'(wr_log.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < wr_log.size()) check("ramp_px", 32'(wr_log[i]), 32'(ramp_exp[i]));
        check("ramp_done_latency", 32'(lat1), 32'd8);
        check("ramp_done_cnt", 32'(done_cnt), 32'd1);
        check("ramp_fd_cnt", 32'(fd_cnt), 32'd1);

        // Backpressure on RUN cycles 3..5
        clear_logs();
        run(2'd0, 4, 2, 1, 24'h0, t0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        fifo.fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            check("bp_wrreq", 32'(fifo.fifo_wrreq), 32'd0);
            check("bp_hold", 32'(fifo.fifo_data), 32'h020000);
            @(posedge clock); #1;
        end
        fifo.fifo_full = 1'b0;
        wait_idle(100);
        check("bp_count", 32'(wr_log.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < wr_log.size()) check("bp_px", 32'(wr_log[i]), 32'(ramp_exp[i]));
        check("bp_done_latency", 32'(done_cyc - t0), 32'(lat1 + 3));

        // Colour bars, bar width 2
        clear_logs();
        run(2'd1, 16, 1, 1, 24'h0, t0);
        wait_idle(100);
        check("bars16_count", 32'(wr_log.size()), 32'd16);
        if (wr_log.size() == 16) begin
            check("bars16_x1", 32'(wr_log[1]), 32'hFFFFFF);
            check("bars16_x2", 32'(wr_log[2]), 32'hFFFF00);
            check("bars16_x4", 32'(wr_log[4]), 32'h00FFFF);
            check("bars16_x8", 32'(wr_log[8]), 32'hFF00FF);
            check("bars16_x15", 32'(wr_log[15]), 32'h000000);
        end

        // Colour bars, bar width 1 with index saturation
        clear_logs();
        run(2'd1, 12, 2, 1, 24'h0, t0);
        wait_idle(100);
        check("bars12_count", 32'(wr_log.size()), 32'd24);
        if (wr_log.size() == 24) begin
            check("bars12_x6", 32'(wr_log[6]), 32'h0000FF);
            check("bars12_x7", 32'(wr_log[7]), 32'h000000);
            check("bars12_x11", 32'(wr_log[11]), 32'h000000);
            check("bars12_l1x0", 32'(wr_log[12]), 32'hFFFFFF);
        end

        // Checkerboard 16x16, two frames
        clear_logs();
        run(2'd2, 16, 16, 2, 24'h0, t0);
        wait_idle(2000);
        check("chk_count", 32'(wr_log.size()), 32'd512);
        if (wr_log.size() == 512) begin
            check("chk_f0_0_0", 32'(wr_log[0]), 32'hFFFFFF);
            check("chk_f0_8_0", 32'(wr_log[8]), 32'h000000);
            check("chk_f0_8_8", 32'(wr_log[136]), 32'hFFFFFF);
            check("chk_f1_0_0", 32'(wr_log[256]), 32'h000000);
        end
        check("chk_fd_cnt", 32'(fd_cnt), 32'd2);
        check("chk_done_cnt", 32'(done_cnt), 32'd1);

        // Zero height: no writes, done pulse only
        clear_logs();
        run(2'd0, 4, 0, 1, 24'h0, t0);
        check("zero_busy", 32'(busy), 32'd0);
        @(negedge clock); #1;
        check("zero_done_cnt", 32'(done_cnt), 32'd1);
        check("zero_writes", 32'(wr_log.size()), 32'd0);
        @(posedge clock); #1;

        // Start while busy is ignored, then asynchronous reset mid-frame
        clear_logs();
        run(2'd3, 16, 4, 2, 24'h123456, t0);
        @(posedge clock); #1;
        start = 1'b1;
        mode  = 2'd0;
        width = WB'(2);
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        check("pre_rst_data", 32'(fifo.fifo_data), 32'h123456);
        reset = 1'b1;
        model_clear();
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_wrreq", 32'(fifo.fifo_wrreq), 32'd0);
        check("arst_data", 32'(fifo.fifo_data), 32'd0);
        check("arst_frame_done", 32'(frame_done), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        check("arst_no_done", 32'(done_cnt), 32'd0);

        clear_logs();
        run(2'd0, 4, 2, 1, 24'h0, t0);
        wait_idle(100);
        check("restart_count", 32'(wr_log.size()), 32'd8);
        if (wr_log.size() == 8) begin
            check("restart_px0", 32'(wr_log[0]), 32'h000000);
            check("restart_px1", 32'(wr_log[1]), 32'h010000);
            check("restart_px7", 32'(wr_log[7]), 32'h030100);
        end

        repeat (2) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
